// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory and the IF/ID register.
// A single BOOT cycle after reset lets the memory address settle before the first real fetch.
module fetch_unit #(
   parameter int                   DATA_W    = 16,
   parameter int                   INSTR_W   = 32,
   parameter logic [DATA_W-1:0]    RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    branch_pc,
   input  logic [DATA_W-1:0]    jump_pc,
   input  logic                 pc_src,
   input  logic                 jump,
   input  logic                 stall,
   output logic [DATA_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0]   imem_rdata,
   output logic [DATA_W-1:0]    if_id_pc,
   output logic [DATA_W-1:0]    if_id_updated_pc,
   output logic [INSTR_W-1:0]   if_id_instr,
   output logic                 if_id_valid,
   output logic [15:0]          redirect_count,
   output logic [15:0]          fetch_count
);

   // state  | meaning
   // S_BOOT | first cycle after reset: pc pinned to RESET_PC, bubble into IF/ID
   // S_RUN  | normal fetch; redirect beats stall, stall holds, else pc += 4
   typedef enum logic {
      S_BOOT = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [DATA_W-1:0]    r_pc;
   logic [DATA_W-1:0]    w_pc_nxt;
   logic [DATA_W-1:0]    r_id_pc;
   logic [DATA_W-1:0]    w_id_pc_nxt;
   logic [DATA_W-1:0]    r_id_upc;
   logic [DATA_W-1:0]    w_id_upc_nxt;
   logic [INSTR_W-1:0]   r_id_instr;
   logic [INSTR_W-1:0]   w_id_instr_nxt;
   logic                 r_id_valid;
   logic                 w_id_valid_nxt;
   logic [15:0]          r_redirect_cnt;
   logic [15:0]          w_redirect_cnt_nxt;
   logic [15:0]          r_fetch_cnt;
   logic [15:0]          w_fetch_cnt_nxt;

   logic                 w_redirect;
   logic [DATA_W-1:0]    w_target;
   logic [DATA_W-1:0]    w_pc_plus4;

   assign w_redirect = jump | pc_src;
   assign w_target   = jump ? jump_pc : branch_pc;
   assign w_pc_plus4 = r_pc + DATA_W'(4);

   always_comb begin
      w_state_nxt        = r_state;
      w_pc_nxt           = r_pc;
      w_id_pc_nxt        = r_id_pc;
      w_id_upc_nxt       = r_id_upc;
      w_id_instr_nxt     = r_id_instr;
      w_id_valid_nxt     = r_id_valid;
      w_redirect_cnt_nxt = r_redirect_cnt;
      w_fetch_cnt_nxt    = r_fetch_cnt;

      case (r_state)
         S_BOOT: begin
            w_state_nxt    = S_RUN;
            w_pc_nxt       = RESET_PC;
            w_id_pc_nxt    = '0;
            w_id_upc_nxt   = '0;
            w_id_instr_nxt = NOP_INSTR;
            w_id_valid_nxt = 1'b0;
         end
         S_RUN: begin
            if (w_redirect) begin
               // Targets are word aligned; low bits from the branch unit are dropped.
               w_pc_nxt       = {w_target[DATA_W-1:2], 2'b00};
               w_id_pc_nxt    = '0;
               w_id_upc_nxt   = '0;
               w_id_instr_nxt = NOP_INSTR;
               w_id_valid_nxt = 1'b0;
               if (r_redirect_cnt != 16'hFFFF)
                  w_redirect_cnt_nxt = r_redirect_cnt + 16'd1;
            end else if (!stall) begin
               w_pc_nxt       = w_pc_plus4;
               w_id_pc_nxt    = r_pc;
               w_id_upc_nxt   = w_pc_plus4;
               w_id_instr_nxt = imem_rdata;
               w_id_valid_nxt = 1'b1;
               if (r_fetch_cnt != 16'hFFFF)
                  w_fetch_cnt_nxt = r_fetch_cnt + 16'd1;
            end
         end
         default: w_state_nxt = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_BOOT;
         r_pc           <= RESET_PC;
         r_id_pc        <= '0;
         r_id_upc       <= '0;
         r_id_instr     <= NOP_INSTR;
         r_id_valid     <= 1'b0;
         r_redirect_cnt <= '0;
         r_fetch_cnt    <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_pc           <= w_pc_nxt;
         r_id_pc        <= w_id_pc_nxt;
         r_id_upc       <= w_id_upc_nxt;
         r_id_instr     <= w_id_instr_nxt;
         r_id_valid     <= w_id_valid_nxt;
         r_redirect_cnt <= w_redirect_cnt_nxt;
         r_fetch_cnt    <= w_fetch_cnt_nxt;
      end
   end

   assign imem_addr        = r_pc;
   assign if_id_pc         = r_id_pc;
   assign if_id_updated_pc = r_id_upc;
   assign if_id_instr      = r_id_instr;
   assign if_id_valid      = r_id_valid;
   assign redirect_count   = r_redirect_cnt;
   assign fetch_count      = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural fetch model predicts every cycle's outputs,
// a monitor compares them after each edge, and directed scenarios add fixed-value checks.
module tb_fetch_unit;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   branch_pc = '0;
   logic [15:0]   jump_pc = '0;
   logic          pc_src = 1'b0;
   logic          jump = 1'b0;
   logic          stall = 1'b0;
   logic [15:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic [15:0]   if_id_pc;
   logic [15:0]   if_id_updated_pc;
   logic [31:0]   if_id_instr;
   logic          if_id_valid;
   logic [15:0]   redirect_count;
   logic [15:0]   fetch_count;

   fetch_unit dut (
      .clk(clk), .rst(rst), .branch_pc(branch_pc), .jump_pc(jump_pc),
      .pc_src(pc_src), .jump(jump), .stall(stall), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .if_id_pc(if_id_pc), .if_id_updated_pc(if_id_updated_pc),
      .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
      .redirect_count(redirect_count), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   // Memory image: each word is tagged with its own address.
   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {~a, a};
   endfunction
   assign imem_rdata = mem_word(imem_addr);

   typedef struct {
      logic [15:0] pc;
      logic [15:0] ipc;
      logic [15:0] upc;
      logic [31:0] instr;
      logic        v;
      logic [15:0] rc;
      logic [15:0] fc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model state
   bit           m_boot;
   int unsigned  m_pc, m_ipc, m_upc, m_rc, m_fc;
   logic [31:0]  m_instr;
   bit           m_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit j, input bit ps, input bit st,
                             input int unsigned jp, input int unsigned bp);
      if (r) begin
         m_boot = 1; m_pc = 0; m_v = 0; m_instr = 32'h13; m_ipc = 0; m_upc = 0;
         m_rc = 0; m_fc = 0;
      end else if (m_boot) begin
         m_boot = 0; m_pc = 0; m_v = 0; m_instr = 32'h13; m_ipc = 0; m_upc = 0;
      end else if (j || ps) begin
         m_pc = ((j ? jp : bp) / 4) * 4;
         m_v = 0; m_instr = 32'h13; m_ipc = 0; m_upc = 0;
         if (m_rc < 65535) m_rc = m_rc + 1;
      end else if (!st) begin
         m_ipc = m_pc;
         m_upc = (m_pc + 4) % 65536;
         m_instr = mem_word(16'(m_pc));
         m_v = 1;
         m_pc = m_upc;
         if (m_fc < 65535) m_fc = m_fc + 1;
      end
   endtask

   task automatic cyc(input bit r, input bit j, input bit ps, input bit st,
                      input logic [15:0] jp, input logic [15:0] bp);
      exp_t e;
      @(negedge clk);
      rst = r; jump = j; pc_src = ps; stall = st; jump_pc = jp; branch_pc = bp;
      model_step(r, j, ps, st, jp, bp);
      e.pc = 16'(m_pc); e.ipc = 16'(m_ipc); e.upc = 16'(m_upc); e.instr = m_instr;
      e.v = m_v; e.rc = 16'(m_rc); e.fc = 16'(m_fc);
      sb.push_back(e);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 16'h0, 16'h0);
   endtask

   // Monitor: one expected entry per edge once stimulus has started.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("imem_addr", 32'(imem_addr), 32'(e.pc));
            chk("if_id_pc", 32'(if_id_pc), 32'(e.ipc));
            chk("if_id_updated_pc", 32'(if_id_updated_pc), 32'(e.upc));
            chk("if_id_instr", if_id_instr, e.instr);
            chk("if_id_valid", 32'(if_id_valid), 32'(e.v));
            chk("redirect_count", 32'(redirect_count), 32'(e.rc));
            chk("fetch_count", 32'(fetch_count), 32'(e.fc));
         end
      end
   end

   initial begin
      // Free run after reset
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 1, 1, 1, 16'h10, 16'h20);
      after_edge();
      chk("rst_valid", 32'(if_id_valid), 32'h0);
      chk("rst_instr", if_id_instr, 32'h13);
      chk("rst_counts", {redirect_count, fetch_count}, 32'h0);
      cyc(0, 1, 0, 0, 16'h80, 16'h0);
      after_edge();
      chk("boot_valid", 32'(if_id_valid), 32'h0);
      chk("boot_addr", 32'(imem_addr), 32'h0);
      chk("boot_rc", 32'(redirect_count), 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      after_edge();
      chk("first_valid", 32'(if_id_valid), 32'h1);
      chk("first_pc", 32'(if_id_pc), 32'h0);
      chk("first_upc", 32'(if_id_updated_pc), 32'h4);
      chk("first_instr", if_id_instr, 32'hFFFF_0000);
      idle(5);
      after_edge();
      chk("run_pc", 32'(if_id_pc), 32'h14);
      chk("run_fc", 32'(fetch_count), 32'd6);

      // Stall at 0x0008
      cyc(1, 0, 0, 0, 0, 0);
      idle(3);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1, 0, 0);
         after_edge();
         chk("stall_addr", 32'(imem_addr), 32'h8);
         chk("stall_id_pc", 32'(if_id_pc), 32'h4);
         chk("stall_fc", 32'(fetch_count), 32'd2);
      end
      cyc(0, 0, 0, 0, 0, 0);
      after_edge();
      chk("resume_pc", 32'(if_id_pc), 32'h8);
      chk("resume_fc", 32'(fetch_count), 32'd3);

      // Branch from 0x0010 to 0x0042 -> 0x0040
      cyc(1, 0, 0, 0, 0, 0);
      idle(5);
      cyc(0, 0, 1, 0, 16'h0, 16'h0042);
      after_edge();
      chk("br_addr", 32'(imem_addr), 32'h40);
      chk("br_valid", 32'(if_id_valid), 32'h0);
      chk("br_instr", if_id_instr, 32'h13);
      chk("br_rc", 32'(redirect_count), 32'd1);

      // Jump beats branch and stall
      cyc(0, 1, 1, 1, 16'h0100, 16'h0200);
      after_edge();
      chk("jmp_addr", 32'(imem_addr), 32'h100);
      chk("jmp_valid", 32'(if_id_valid), 32'h0);
      chk("jmp_rc", 32'(redirect_count), 32'd2);

      // PC wrap at top of address space
      cyc(0, 1, 0, 0, 16'hFFFE, 16'h0);
      after_edge();
      chk("wrap_addr0", 32'(imem_addr), 32'hFFFC);
      cyc(0, 0, 0, 0, 0, 0);
      after_edge();
      chk("wrap_id_pc", 32'(if_id_pc), 32'hFFFC);
      chk("wrap_upc", 32'(if_id_updated_pc), 32'h0);
      chk("wrap_addr", 32'(imem_addr), 32'h0);

      // Reset during stall at 0x0024, then BOOT ignores redirect
      cyc(1, 0, 0, 0, 0, 0);
      idle(10);
      cyc(0, 0, 0, 1, 0, 0);
      after_edge();
      chk("pre_rst_addr", 32'(imem_addr), 32'h24);
      cyc(1, 1, 1, 1, 16'h80, 16'h90);
      after_edge();
      chk("mid_rst_addr", 32'(imem_addr), 32'h0);
      chk("mid_rst_valid", 32'(if_id_valid), 32'h0);
      chk("mid_rst_counts", {redirect_count, fetch_count}, 32'h0);
      cyc(0, 1, 1, 0, 16'h80, 16'h90);
      after_edge();
      chk("boot2_addr", 32'(imem_addr), 32'h0);
      chk("boot2_rc", 32'(redirect_count), 32'h0);
      cyc(0, 0, 0, 0, 0, 0);
      after_edge();
      chk("boot2_fetch", 32'(if_id_valid), 32'h1);

      // Random traffic
      for (int k = 0; k < 600; k++)
         cyc(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(5) == 0),
             ($urandom_range(3) == 0), 16'($urandom_range(16'hFFFF)),
             16'($urandom_range(16'hFFFF)));

      repeat (3) @(posedge clk);
      #3;
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
